// File: rtl/gcbp_frame_ring_if.sv
// Bundles the line-timing inputs and the ring/BRAM outputs of the GCBP frame ring controller.
interface gcbp_frame_ring_if #(
  parameter int C_LOC_BITS  = 2,
  parameter int C_ADDR_BITS = 9,
  parameter int C_LINE_BITS = 10
);
  logic [C_LINE_BITS-1:0] i_line_count;
  logic                   i_line_valid;
  logic                   i_new_frame;
  logic                   i_rd_busy;
  logic [C_LOC_BITS-1:0]  o_next_loc;
  logic [C_LOC_BITS-1:0]  o_curr_loc;
  logic [C_LOC_BITS-1:0]  o_prev_loc;
  logic                   o_curr_valid;
  logic                   o_prev_valid;
  logic                   o_pair_ready;
  logic                   o_frame_dropped;
  logic [15:0]            o_drop_count;
  logic [C_ADDR_BITS-1:0] o_bram_wr_addr;
  logic                   o_bram_wr_en;

  modport master (
    output i_line_count, i_line_valid, i_new_frame, i_rd_busy,
    input  o_next_loc, o_curr_loc, o_prev_loc, o_curr_valid, o_prev_valid,
           o_pair_ready, o_frame_dropped, o_drop_count, o_bram_wr_addr, o_bram_wr_en
  );

  modport slave (
    input  i_line_count, i_line_valid, i_new_frame, i_rd_busy,
    output o_next_loc, o_curr_loc, o_prev_loc, o_curr_valid, o_prev_valid,
           o_pair_ready, o_frame_dropped, o_drop_count, o_bram_wr_addr, o_bram_wr_en
  );
endinterface

// File: rtl/gcbp_frame_ring_ctrl.sv
// Ring of sub-image slots in the GCBP BRAM: write-slot addressing and (prev, curr) publication
// to the correlator, with frames held in spare slots or dropped while the reader is busy.
module gcbp_frame_ring_ctrl #(
  parameter int C_NUM_LOCS    = 3,
  parameter int C_LOC_BITS    = 2,
  parameter int C_OFFSET_LOG2 = 7,
  parameter int C_ADDR_BITS   = 9,
  parameter int C_LINE_BITS   = 10,
  parameter int C_MAX_LINES   = 64
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  gcbp_frame_ring_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  localparam logic [C_LOC_BITS-1:0]  LOC_LAST  = C_LOC_BITS'(C_NUM_LOCS - 1);
  localparam logic [C_LOC_BITS-1:0]  LOC_PREV0 = C_LOC_BITS'(C_NUM_LOCS - 2);
  localparam logic [C_LINE_BITS:0]   MAX_LINES = (C_LINE_BITS + 1)'(C_MAX_LINES);
  localparam int                     SUM_W     = C_LOC_BITS + C_OFFSET_LOG2;

  function automatic logic [C_LOC_BITS-1:0] loc_inc(input logic [C_LOC_BITS-1:0] x);
    return (x == LOC_LAST) ? '0 : x + C_LOC_BITS'(1);
  endfunction

  function automatic logic [C_LOC_BITS-1:0] loc_dec(input logic [C_LOC_BITS-1:0] x);
    return (x == '0) ? LOC_LAST : x - C_LOC_BITS'(1);
  endfunction

  state_t                state, state_nxt;
  logic [C_LOC_BITS-1:0] next_loc, next_loc_nxt;
  logic [C_LOC_BITS-1:0] curr_loc, curr_loc_nxt;
  logic [C_LOC_BITS-1:0] prev_loc, prev_loc_nxt;
  logic                  curr_valid, curr_valid_nxt;
  logic                  prev_valid, prev_valid_nxt;
  logic                  pair_ready, pair_ready_nxt;
  logic                  frame_dropped, frame_dropped_nxt;
  logic [15:0]           drop_cnt, drop_cnt_nxt;
  logic [1:0]            done_cnt, done_cnt_nxt;
  logic [SUM_W-1:0]      addr_full;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state         <= ST_IDLE;
      next_loc      <= '0;
      curr_loc      <= LOC_LAST;
      prev_loc      <= LOC_PREV0;
      curr_valid    <= 1'b0;
      prev_valid    <= 1'b0;
      pair_ready    <= 1'b0;
      frame_dropped <= 1'b0;
      drop_cnt      <= '0;
      done_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      next_loc      <= next_loc_nxt;
      curr_loc      <= curr_loc_nxt;
      prev_loc      <= prev_loc_nxt;
      curr_valid    <= curr_valid_nxt;
      prev_valid    <= prev_valid_nxt;
      pair_ready    <= pair_ready_nxt;
      frame_dropped <= frame_dropped_nxt;
      drop_cnt      <= drop_cnt_nxt;
      done_cnt      <= done_cnt_nxt;
    end
  end

  // Branch order matters: a finished frame with the reader free always publishes, even from PEND.
  always_comb begin
    state_nxt         = state;
    next_loc_nxt      = next_loc;
    curr_loc_nxt      = curr_loc;
    prev_loc_nxt      = prev_loc;
    curr_valid_nxt    = curr_valid;
    prev_valid_nxt    = prev_valid;
    pair_ready_nxt    = 1'b0;
    frame_dropped_nxt = 1'b0;
    drop_cnt_nxt      = drop_cnt;
    done_cnt_nxt      = (bus.i_new_frame && done_cnt != 2'd2) ? done_cnt + 2'd1 : done_cnt;

    if (bus.i_new_frame && !bus.i_rd_busy) begin
      curr_loc_nxt   = next_loc;
      prev_loc_nxt   = loc_dec(next_loc);
      next_loc_nxt   = loc_inc(next_loc);
      state_nxt      = ST_IDLE;
      pair_ready_nxt = 1'b1;
      curr_valid_nxt = (done_cnt_nxt >= 2'd1);
      prev_valid_nxt = (done_cnt_nxt == 2'd2);
    end else if (bus.i_new_frame) begin
      if (loc_inc(next_loc) != prev_loc) begin
        next_loc_nxt = loc_inc(next_loc);
        state_nxt    = ST_PEND;
      end else begin
        // No spare slot left: the write slot is reused and this frame is lost.
        frame_dropped_nxt = 1'b1;
        drop_cnt_nxt      = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
      end
    end else if (!bus.i_rd_busy && state == ST_PEND) begin
      curr_loc_nxt   = loc_dec(next_loc);
      prev_loc_nxt   = loc_dec(loc_dec(next_loc));
      state_nxt      = ST_IDLE;
      pair_ready_nxt = 1'b1;
      curr_valid_nxt = (done_cnt >= 2'd1);
      prev_valid_nxt = (done_cnt == 2'd2);
    end
  end

  assign addr_full = {next_loc, bus.i_line_count[C_OFFSET_LOG2-1:0]};

  assign bus.o_bram_wr_addr  = C_ADDR_BITS'(addr_full);
  assign bus.o_bram_wr_en    = bus.i_line_valid && ({1'b0, bus.i_line_count} < MAX_LINES);
  assign bus.o_next_loc      = next_loc;
  assign bus.o_curr_loc      = curr_loc;
  assign bus.o_prev_loc      = prev_loc;
  assign bus.o_curr_valid    = curr_valid;
  assign bus.o_prev_valid    = prev_valid;
  assign bus.o_pair_ready    = pair_ready;
  assign bus.o_frame_dropped = frame_dropped;
  assign bus.o_drop_count    = drop_cnt;

endmodule
